// File: rtl/mina_fetch_unit_pkg.sv
// Shared types for the MINAv2 decoupled fetch stage: ID payload, fetch FSM states
// and the instruction address step.
package mina_fetch_unit_pkg;

  localparam int unsigned MINA_INSN_BYTES = 4;
  localparam int unsigned MINA_XLEN       = 32;

  typedef struct packed {
    logic [MINA_XLEN-1:0] ia;
    logic [MINA_XLEN-1:0] ia_plus_4;
    logic [MINA_XLEN-1:0] ir;
  } id_params_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2
  } fetch_state_e;

  // Sequential instruction address; wraps modulo 2^32.
  function automatic logic [MINA_XLEN-1:0] mina_next_ia(input logic [MINA_XLEN-1:0] ia);
    return ia + MINA_XLEN'(MINA_INSN_BYTES);
  endfunction

endpackage

// File: rtl/mina_sync_fifo.sv
// Synchronous FIFO with async reset, flush and occupancy count.
// Flush wins over push/pop in the same cycle; a push into a full FIFO is accepted only alongside a pop.
module mina_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full     = (count_r == CW'(DEPTH));
  assign empty    = (count_r == {CW{1'b0}});
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
    end
  end

  // Storage array; only written on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mina_fetch_unit.sv
// Decoupled IF stage: credit-limited IMEM request issue, in-order response capture into a
// prefetch FIFO, ID backpressure, branch redirect with in-flight discard, and halt/drain.
module mina_fetch_unit
  import mina_fetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] INITIAL_IA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output id_params_t  id_params,
  input  logic        branch_req,
  input  logic [31:0] branch_ia,
  input  logic        halt_req,
  output logic        halt_ack
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW  = $bits(id_params_t);

  fetch_state_e   state_r;
  fetch_state_e   state_nxt_s;
  logic [31:0]    fetch_ia_r;
  logic [31:0]    rsp_ia_r;
  logic [CW-1:0]  outstanding_r;
  logic [CW-1:0]  outstanding_nxt_s;
  logic [CW-1:0]  drop_cnt_r;
  logic [CW-1:0]  drop_cnt_nxt_s;
  logic [FCW-1:0] fifo_count_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           req_valid_s;
  logic           issue_s;
  logic           rsp_s;
  logic           push_s;
  logic           pop_s;
  id_params_t     push_data_s;
  id_params_t     head_s;

  // Credits: in-flight requests plus buffered entries never exceed the FIFO depth.
  assign req_valid_s = (state_r == S_RUN) && !branch_req &&
                       (outstanding_r < CW'(MAX_OUTSTANDING)) &&
                       ((32'(outstanding_r) + 32'(fifo_count_s)) < 32'(FIFO_DEPTH));
  assign issue_s     = req_valid_s && imem_req_ready;
  assign rsp_s       = imem_rsp_valid && (outstanding_r != {CW{1'b0}});
  assign push_s      = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !branch_req;
  assign pop_s       = id_valid && id_ready;

  assign imem_req_valid = req_valid_s;
  assign imem_addr      = fetch_ia_r;
  assign id_valid       = !fifo_empty_s && !branch_req;
  assign id_params      = head_s;
  assign halt_ack       = (state_r == S_HALT) && (outstanding_r == {CW{1'b0}});

  assign push_data_s.ia        = rsp_ia_r;
  assign push_data_s.ia_plus_4 = mina_next_ia(rsp_ia_r);
  assign push_data_s.ir        = imem_rsp_data;

  mina_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (branch_req),
    .pop_data  (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Fetch FSM next-state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: state_nxt_s = S_RUN;
      S_RUN: begin
        if (halt_req) begin
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_HALT: begin
        if (!halt_req) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_HALT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // In-flight and discard counters; a branch re-arms discard for everything still in flight.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    drop_cnt_nxt_s    = drop_cnt_r;
    case ({issue_s, rsp_s})
      2'b10:   outstanding_nxt_s = outstanding_r + CW'(1);
      2'b01:   outstanding_nxt_s = outstanding_r - CW'(1);
      default: outstanding_nxt_s = outstanding_r;
    endcase
    if (branch_req) begin
      drop_cnt_nxt_s = outstanding_r - CW'(rsp_s);
    end else if (imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
      drop_cnt_nxt_s = drop_cnt_r - CW'(1);
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_cnt_r    <= drop_cnt_nxt_s;
    end
  end

  // Request and response address tracking; a redirect resets both streams to the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ia_r <= INITIAL_IA;
      rsp_ia_r   <= INITIAL_IA;
    end else if (branch_req) begin
      fetch_ia_r <= branch_ia;
      rsp_ia_r   <= branch_ia;
    end else begin
      if (issue_s) begin
        fetch_ia_r <= mina_next_ia(fetch_ia_r);
      end
      if (push_s) begin
        rsp_ia_r <= mina_next_ia(rsp_ia_r);
      end
    end
  end

endmodule
